// File: rtl/controlador_painel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : painel_pkg                                                 |
// | Description : Shared constants and types for the panel sequencer:        |
// |               display register width, mode-select codes, FSM states.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package painel_pkg;

  // Width of the rotating display register driven by the sequencer.
  localparam int LARGURA = 16;

  // Mode-select codes {ch1,ch0} understood by the display register.
  localparam logic [1:0] MODO_CARREGA = 2'b00; // parallel load
  localparam logic [1:0] MODO_ESQ     = 2'b01; // shift toward index 0
  localparam logic [1:0] MODO_DIR     = 2'b10; // shift toward index 15
  localparam logic [1:0] MODO_MANTEM  = 2'b11; // hold

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    RODA    = 2'd2,
    FIM     = 2'd3
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/controlador_painel_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : controlador_painel_if                                      |
// | Description : Command and register-drive bundle of the panel sequencer.  |
// |   start, mensagem, sentido, continuo, pausa, divisor : commands          |
// |   ch0, ch1, cadeiaDeBits                             : register drive    |
// |   ocupado, volta                                     : status            |
// |   master = command source, slave = sequencer                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface controlador_painel_if #(
  parameter int DIV_W = 24
);
  import painel_pkg::*;

  logic               start;
  logic [LARGURA-1:0] mensagem;
  logic               sentido;
  logic               continuo;
  logic               pausa;
  logic [DIV_W-1:0]   divisor;
  logic               ch0;
  logic               ch1;
  logic [LARGURA-1:0] cadeiaDeBits;
  logic               ocupado;
  logic               volta;

  modport master (
    output start, mensagem, sentido, continuo, pausa, divisor,
    input  ch0, ch1, cadeiaDeBits, ocupado, volta
  );

  modport slave (
    input  start, mensagem, sentido, continuo, pausa, divisor,
    output ch0, ch1, cadeiaDeBits, ocupado, volta
  );

endinterface
`default_nettype wire

// File: rtl/controlador_painel_divisor_passo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divisor_passo                                              |
// | Description : Step-rate prescaler. Counts 0..limite and raises tick for  |
// |               the one cycle in which the count equals limite, wrapping   |
// |               to 0 at that point.                                        |
// |   clk, rst  : clock, async active-high reset                             |
// |   limpa     : synchronous clear (no tick while asserted)                 |
// |   congela   : freeze count (no tick while asserted)                      |
// |   limite    : terminal count (cycles per tick minus 1)                   |
// |   tick      : one-cycle step request                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module divisor_passo #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             limpa,
  input  logic             congela,
  input  logic [DIV_W-1:0] limite,
  output logic             tick
);

  logic [DIV_W-1:0] cont_q;
  logic [DIV_W-1:0] cont_d;

  assign tick = !limpa && !congela && (cont_q == limite);

  always_comb begin
    cont_d = cont_q;
    if (limpa) begin
      cont_d = '0;
    end else if (!congela) begin
      cont_d = tick ? '0 : cont_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/controlador_painel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : controlador_painel                                         |
// | Description : Sequencer feeding the 16-bit rotating display register.    |
// |               Latches a message, issues one load cycle, then emits a     |
// |               rotate code every divisor+1 cycles; optionally stops after |
// |               one revolution.                                            |
// |   clk, rst  : shared clock, async active-high reset                      |
// |   bus       : controlador_painel_if.slave (commands in, register drive   |
// |               and status out; all outputs registered)                    |
// | Option      : CONTROLADOR_PAINEL_VAIVEM_EN - ping-pong direction after   |
// |               each revolution in continuous mode                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module controlador_painel
  import painel_pkg::*;
#(
  parameter int DIV_W  = 24,
  parameter int PASSOS = 16
) (
  input logic                 clk,
  input logic                 rst,
  controlador_painel_if.slave bus
);

  localparam int PW = (PASSOS > 1) ? $clog2(PASSOS) : 1;

  estado_t            estado_q, estado_d;
  logic [1:0]         modo_q, modo_d;
  logic [LARGURA-1:0] cadeia_q, cadeia_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PW-1:0]      passo_q, passo_d;
  logic               ocupado_q, ocupado_d;
  logic               volta_q, volta_d;
  // Set on the last shift of a single revolution: the next cycle goes to FIM.
  logic               parar_q, parar_d;
  logic               sentido_ef;
  logic               congela;
  logic               tick;

`ifdef CONTROLADOR_PAINEL_VAIVEM_EN
  logic vaivem_q, vaivem_d;
  assign sentido_ef = bus.sentido ^ vaivem_q;
`else
  assign sentido_ef = bus.sentido;
`endif

  // The prescaler runs from the load cycle on, so the first shift lands
  // divisor+1 cycles after the load code.
  assign congela = bus.pausa ||
                   !((estado_q == CARREGA) || ((estado_q == RODA) && !parar_q));

  divisor_passo #(.DIV_W(DIV_W)) u_divisor_passo (
    .clk     (clk),
    .rst     (rst),
    .limpa   (bus.start),
    .congela (congela),
    .limite  (div_q),
    .tick    (tick)
  );

  always_comb begin
    estado_d = estado_q;
    modo_d   = MODO_MANTEM;
    cadeia_d = cadeia_q;
    div_d    = div_q;
    passo_d  = passo_q;
    volta_d  = 1'b0;
    parar_d  = parar_q;
`ifdef CONTROLADOR_PAINEL_VAIVEM_EN
    vaivem_d = vaivem_q;
`endif
    if (bus.start) begin
      // Accepted in any state: abort and restart with the new message.
      estado_d = CARREGA;
      modo_d   = MODO_CARREGA;
      cadeia_d = bus.mensagem;
      div_d    = bus.divisor;
      passo_d  = '0;
      parar_d  = 1'b0;
`ifdef CONTROLADOR_PAINEL_VAIVEM_EN
      vaivem_d = 1'b0;
`endif
    end else begin
      case (estado_q)
        CARREGA, RODA: begin
          if (parar_q) begin
            estado_d = FIM;
            parar_d  = 1'b0;
          end else begin
            estado_d = RODA;
            if (tick) begin
              modo_d = sentido_ef ? MODO_DIR : MODO_ESQ;
              if (passo_q == PW'(PASSOS - 1)) begin
                passo_d = '0;
                volta_d = 1'b1;
                if (!bus.continuo) begin
                  parar_d = 1'b1;
                end
`ifdef CONTROLADOR_PAINEL_VAIVEM_EN
                else begin
                  vaivem_d = ~vaivem_q;
                end
`endif
              end else begin
                passo_d = passo_q + 1'b1;
              end
            end
          end
        end
        FIM:     estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      modo_q    <= MODO_MANTEM;
      cadeia_q  <= '0;
      div_q     <= '0;
      passo_q   <= '0;
      ocupado_q <= 1'b0;
      volta_q   <= 1'b0;
      parar_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      modo_q    <= modo_d;
      cadeia_q  <= cadeia_d;
      div_q     <= div_d;
      passo_q   <= passo_d;
      ocupado_q <= ocupado_d;
      volta_q   <= volta_d;
      parar_q   <= parar_d;
    end
  end

`ifdef CONTROLADOR_PAINEL_VAIVEM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vaivem_q <= 1'b0;
    end else begin
      vaivem_q <= vaivem_d;
    end
  end
`endif

  assign bus.ch1          = modo_q[1];
  assign bus.ch0          = modo_q[0];
  assign bus.cadeiaDeBits = cadeia_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.volta        = volta_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_painel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_controlador_painel                                      |
// | Description : Directed self-checking bench for controlador_painel.       |
// |               Each driven cycle pushes the predicted outputs into a      |
// |               queue; they are popped and compared after the clock edge.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_controlador_painel;
  import painel_pkg::*;

  localparam int DIV_W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  controlador_painel_if #(.DIV_W(DIV_W)) bus ();

  controlador_painel #(.DIV_W(DIV_W), .PASSOS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  modo;
    logic        volta;
    logic        ocupado;
    logic [15:0] cadeia;
  } saida_t;

  saida_t fila[$];
  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 load, 2 rotating, 3 end.
  // Shifts happen on every (divisor+1)-th unpaused cycle after the load.
  int          m_fase;
  logic [15:0] m_msg;
  int          m_div;
  int          m_ativos;
  bit          m_pend;
  bit          m_tog;

  function automatic saida_t observado();
    return {bus.ch1, bus.ch0, bus.volta, bus.ocupado, bus.cadeiaDeBits};
  endfunction

  task automatic modelo_reset();
    m_fase = 0; m_msg = 16'h0; m_div = 0; m_ativos = 0; m_pend = 0; m_tog = 0;
  endtask

  function automatic saida_t prever();
    saida_t e;
    e.modo = MODO_MANTEM; e.volta = 1'b0; e.ocupado = 1'b1; e.cadeia = 16'h0;
    if (bus.start) begin
      m_fase = 1; m_msg = bus.mensagem; m_div = int'(bus.divisor);
      m_ativos = 0; m_pend = 0; m_tog = 0;
      e.modo = MODO_CARREGA;
    end else begin
      case (m_fase)
        1, 2: begin
          if (m_pend) begin
            m_fase = 3; m_pend = 0;
          end else begin
            m_fase = 2;
            if (!bus.pausa) begin
              m_ativos++;
              if (m_ativos % (m_div + 1) == 0) begin
                e.modo = (bus.sentido ^ m_tog) ? MODO_DIR : MODO_ESQ;
                if ((m_ativos / (m_div + 1)) % 16 == 0) begin
                  e.volta = 1'b1;
                  if (!bus.continuo) m_pend = 1;
`ifdef CONTROLADOR_PAINEL_VAIVEM_EN
                  else m_tog = ~m_tog;
`endif
                end
              end
            end
          end
        end
        3: begin m_fase = 0; e.ocupado = 1'b0; end
        default: e.ocupado = 1'b0;
      endcase
    end
    e.cadeia = m_msg;
    return e;
  endfunction

  task automatic conferir(input string tag, input saida_t obs, input saida_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed modo=%b volta=%b ocupado=%b cadeia=%h expected modo=%b volta=%b ocupado=%b cadeia=%h",
             tag, obs.modo, obs.volta, obs.ocupado, obs.cadeia,
             exp.modo, exp.volta, exp.ocupado, exp.cadeia);
    end
  endtask

  task automatic ciclo(input string tag);
    saida_t exp;
    fila.push_back(prever());
    @(posedge clk);
    #1;
    exp = fila.pop_front();
    conferir(tag, observado(), exp);
  endtask

  task automatic iniciar(input string tag, input logic [15:0] msg, input int div,
                         input logic sen, input logic cont);
    bus.mensagem = msg;
    bus.divisor  = DIV_W'(div);
    bus.sentido  = sen;
    bus.continuo = cont;
    bus.start    = 1'b1;
    ciclo(tag);
    bus.start    = 1'b0;
  endtask

  saida_t repouso;

  initial begin
    repouso = '{modo: MODO_MANTEM, volta: 1'b0, ocupado: 1'b0, cadeia: 16'h0};
    bus.start = 1'b0; bus.mensagem = 16'h0; bus.sentido = 1'b0;
    bus.continuo = 1'b0; bus.pausa = 1'b0; bus.divisor = '0;
    modelo_reset();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    conferir("reset_inicial", observado(), repouso);
    rst = 1'b0;
    repeat (3) ciclo("ocioso");

    // 1: reset in the middle of a rotation (divisor 3, around step 7)
    iniciar("t1_carga", 16'h3C3C, 3, 1'b0, 1'b1);
    repeat (29) ciclo("t1_roda");
    rst = 1'b1;
    #1;
    conferir("t1_reset_async", observado(), repouso);
    @(posedge clk);
    #1;
    conferir("t1_reset_borda", observado(), repouso);
    rst = 1'b0;
    modelo_reset();
    repeat (8) ciclo("t1_pos_reset");

    // 2: single revolution, divisor 2, toward index 0
    iniciar("t2_carga", 16'hA5F0, 2, 1'b0, 1'b0);
    repeat (52) ciclo("t2_roda");

    // 3: divisor 0, toward index 15, continuous
    iniciar("t3_carga", 16'h8001, 0, 1'b1, 1'b1);
    repeat (40) ciclo("t3_roda");

    // 4: pause mid-run, then a direction change mid-run
    iniciar("t4_carga", 16'h00FF, 4, 1'b0, 1'b1);
    repeat (13) ciclo("t4_antes");
    bus.pausa = 1'b1;
    repeat (10) ciclo("t4_pausa");
    bus.pausa = 1'b0;
    repeat (12) ciclo("t4_retoma");
    bus.sentido = 1'b1;
    repeat (15) ciclo("t4_sentido");
    bus.sentido = 1'b0;

    // 5: restart at step 9, start coinciding with pausa
    iniciar("t5_carga", 16'h1234, 1, 1'b0, 1'b0);
    repeat (18) ciclo("t5_roda");
    bus.pausa = 1'b1;
    iniciar("t5_recarga", 16'h0001, 1, 1'b0, 1'b0);
    bus.pausa = 1'b0;
    repeat (38) ciclo("t5_fim");

    // 6: continuous, toward index 0 (ping-pong when enabled)
    iniciar("t6_carga", 16'hF00D, 0, 1'b0, 1'b1);
    repeat (50) ciclo("t6_roda");

    // Wind down through a single revolution back to idle
    iniciar("t7_carga", 16'h5A5A, 0, 1'b1, 1'b0);
    repeat (20) ciclo("t7_roda");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controlador_painel.md
Name: controlador_painel

Overview:
Sequencer directly upstream of the 16-bit universal (rotating) display register of the electronic panel. It captures a 16-bit message, issues a one-cycle load, then drives rotate steps at a programmable rate. Steps go toward index 0 or toward index 15. Its outputs ch0, ch1 and cadeiaDeBits connect one-to-one to the register's mode-select and parallel-load inputs; both blocks share clk.

Parameters:
DIV_W, 24, width of the step-rate prescaler counter
PASSOS, 16, rotate steps per full revolution; equals register width

Ports:
clk  input  1  system clock, shared with the display register
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; capture mensagem and begin
mensagem  input  16  message pattern sampled on start
sentido  input  1  0 = rotate toward index 0, 1 = toward index 15; sampled each step
continuo  input  1  1 = rotate forever; 0 = stop after one revolution
pausa  input  1  level; freezes stepping while high
divisor  input  DIV_W  clk cycles per step minus 1; sampled on start
ch0  output  1  register mode select, LSB
ch1  output  1  register mode select, MSB
cadeiaDeBits  output  16  parallel-load data to the register
ocupado  output  1  high in every state except OCIOSO
volta  output  1  one-cycle pulse at the end of each full revolution

Behaviour:
- Mode code {ch1,ch0}: 00 load, 01 shift toward index 0 (takes i+1), 10 shift toward index 15 (takes i-1), 11 hold. All outputs are registered.
- Reset (async, any state, including mid-rotation):
  - state OCIOSO; {ch1,ch0}=11; cadeiaDeBits=0; ocupado=0; volta=0; prescaler and step counter cleared.
- States:
  - OCIOSO: hold code. start -> latch mensagem into cadeiaDeBits and divisor into the internal register -> CARREGA.
  - CARREGA: exactly one cycle with code 00 -> RODA; prescaler cleared.
  - RODA: hold code, except one cycle with the shift code when the prescaler reaches the latched divisor. Prescaler wraps to 0 on that cycle. Step counter increments on each shift cycle.
  - RODA with pausa high: prescaler and counter frozen, hold code emitted, state stays RODA. Stepping resumes where it left off.
  - RODA at step PASSOS-1: volta pulses in the same cycle as the last shift code; step counter wraps to 0. If continuo=0 -> FIM, otherwise stay in RODA.
  - FIM: one cycle of hold code -> OCIOSO.
- Latency:
  - start to load code: 1 cycle.
  - First shift: divisor+1 cycles after the load cycle.
  - Shift period: divisor+1 cycles.
- divisor=0: a shift on every RODA cycle.
- start outside OCIOSO: abort and restart. New message latched, next state CARREGA, counters cleared.
- start in the same cycle as pausa: start wins.
- sentido changes mid-run: take effect at the next shift; the step count is not reset.

Optional Feature:
CONTROLADOR_PAINEL_VAIVEM_EN
- Defined: after each full revolution in continuous mode, the effective direction inverts, giving ping-pong scrolling; sentido is XORed with an internal toggle. The toggle clears on reset and on start.
- Undefined: no toggle logic; direction follows sentido only.

Decomposition:
- Shared package painel_pkg holds:
  - mode-code constants MODO_CARREGA=2'b00, MODO_ESQ=2'b01, MODO_DIR=2'b10, MODO_MANTEM=2'b11;
  - the state enum {OCIOSO, CARREGA, RODA, FIM};
  - the register width constant 16.
- One natural sub-module: divisor_passo, the prescaler emitting a one-cycle tick with clear and freeze inputs.

Test Plan:
1. Reset mid-RODA (DIV=3, step 7) -> next edge: code 11, ocupado=0, cadeiaDeBits=0; no further shift codes.
2. start, mensagem=16'hA5F0, divisor=2, sentido=0, continuo=0:
   - cycle 1: code 00, cadeiaDeBits=A5F0;
   - then shift code 01 every 3rd cycle, 16 times;
   - volta on the 16th shift, then FIM, then ocupado=0.
3. divisor=0, sentido=1, continuo=1 -> code 10 every cycle; volta every 16 cycles.
4. pausa high for 10 cycles mid-run (divisor=4) -> no shift codes while high; next shift exactly (4 − prescaler value at pause entry) + 1 cycles after release.
5. start reissued at step 9 with mensagem=16'h0001 -> code 00 next cycle with the new data; volta only after 16 more shifts.
6. With VAIVEM_EN, continuo=1, sentido=0 -> 16 shifts with code 01, volta, then 16 shifts with code 10, then 01 again.
